// File: rtl/deserializador_align_pkg.sv
// Shared definitions for the comma-aligned deserializer.
// State encodings match the serializer and decoder on the same link.
package deserializador_align_pkg;

    typedef enum logic [1:0] {
        ST_HUNT   = 2'd0,
        ST_SYNC   = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    localparam logic [7:0] DEF_COMMA = 8'hBC;

    // Counter width for values 0..n-1, never narrower than one bit.
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/deserializador_align_shift.sv
// Serial shift register and word-phase counter.
// Exposes the candidate word including the bit being presented.
module deser_shift_align
    import deserializador_align_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             data,
    input  logic             clr,
    output logic [WIDTH-1:0] cand,
    output logic             word_end
);

    localparam int BW = cnt_w(WIDTH);

    // Only WIDTH-1 history bits are needed; the newest bit comes from data.
    logic [WIDTH-2:0] sh;
    logic [BW-1:0]    bit_cnt;

    assign cand     = {sh, data};
    assign word_end = (bit_cnt == BW'(WIDTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh      <= '0;
            bit_cnt <= '0;
        end else if (en) begin
            sh <= cand[WIDTH-2:0];
            if (clr || word_end) begin
                bit_cnt <= '0;
            end else begin
                bit_cnt <= bit_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/deserializador_align.sv
// Serial-to-parallel converter with comma-based word alignment.
// Hunts for COMMA, confirms it LOCK_COUNT times, then emits words.
module deserializador_align
    import deserializador_align_pkg::*;
#(
    parameter int               WIDTH      = 8,
    parameter logic [WIDTH-1:0] COMMA      = WIDTH'(DEF_COMMA),
    parameter int               LOCK_COUNT = 3,
    parameter int               MAX_GAP    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             data,
    input  logic             en,
    input  logic             DK,
    output logic [WIDTH-1:0] out,
    output logic             out_DK,
    output logic             out_valid,
    output logic             locked
);

    localparam int CW = cnt_w(LOCK_COUNT + 1);
    localparam int GW = cnt_w(MAX_GAP + 1);

    state_t           state;
    logic [CW-1:0]    comma_cnt;
    logic [GW-1:0]    gap_cnt;
    logic [CW-1:0]    comma_nxt;
    logic [GW-1:0]    gap_nxt;
    logic [WIDTH-1:0] cand;
    logic             word_end;
    logic             is_comma;
    logic             hunting;

    assign hunting   = (state == ST_HUNT);
    assign is_comma  = (cand == COMMA);
    assign comma_nxt = comma_cnt + 1'b1;
    assign gap_nxt   = (gap_cnt == GW'(MAX_GAP)) ? gap_cnt
                                                 : gap_cnt + 1'b1;

    // Bit phase is pinned to zero while hunting so it restarts on a match.
    deser_shift_align #(
        .WIDTH(WIDTH)
    ) u_shift (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en),
        .data    (data),
        .clr     (hunting),
        .cand    (cand),
        .word_end(word_end)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_HUNT;
            comma_cnt <= '0;
            gap_cnt   <= '0;
            out       <= '0;
            out_DK    <= 1'b0;
            out_valid <= 1'b0;
            locked    <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            if (en) begin
                unique case (state)
                    ST_HUNT: begin
                        if (is_comma) begin
                            comma_cnt <= CW'(1);
                            gap_cnt   <= '0;
                            if (LOCK_COUNT == 1) begin
                                state  <= ST_LOCKED;
                                locked <= 1'b1;
                            end else begin
                                state <= ST_SYNC;
                            end
                        end
                    end
                    ST_SYNC: begin
                        if (word_end) begin
                            if (is_comma) begin
                                comma_cnt <= comma_nxt;
                                if (comma_nxt == CW'(LOCK_COUNT)) begin
                                    state   <= ST_LOCKED;
                                    locked  <= 1'b1;
                                    gap_cnt <= '0;
                                end
                            end else begin
                                state     <= ST_HUNT;
                                comma_cnt <= '0;
                            end
                        end
                    end
                    ST_LOCKED: begin
                        if (word_end) begin
                            out       <= cand;
                            out_DK    <= DK;
                            out_valid <= 1'b1;
                            if (is_comma) begin
                                gap_cnt <= '0;
                            end else if (MAX_GAP > 0) begin
                                // The word that exhausts the gap budget is still delivered.
                                if (gap_nxt == GW'(MAX_GAP)) begin
                                    state     <= ST_HUNT;
                                    locked    <= 1'b0;
                                    gap_cnt   <= '0;
                                    comma_cnt <= '0;
                                end else begin
                                    gap_cnt <= gap_nxt;
                                end
                            end
                        end
                    end
                    default: begin
                        state     <= ST_HUNT;
                        locked    <= 1'b0;
                        comma_cnt <= '0;
                        gap_cnt   <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_deserializador_align.sv
// Bench for deserializador_align: three configurations share one serial
// stream and are compared every cycle against a bit-stream reference model.
module tb_deserializador_align;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic data = 1'b0;
    logic en = 1'b0;
    logic dk = 1'b0;

    logic [7:0] out0, out1;
    logic [9:0] out2;
    logic dk0, dk1, dk2, v0, v1, v2, l0, l1, l2;

    always #5 clk = ~clk;

    deserializador_align #(.WIDTH(8), .COMMA(8'hBC), .LOCK_COUNT(3), .MAX_GAP(4)) u0 (
        .clk(clk), .rst_n(rst_n), .data(data), .en(en), .DK(dk),
        .out(out0), .out_DK(dk0), .out_valid(v0), .locked(l0));

    deserializador_align #(.WIDTH(8), .COMMA(8'hBC), .LOCK_COUNT(3), .MAX_GAP(0)) u1 (
        .clk(clk), .rst_n(rst_n), .data(data), .en(en), .DK(dk),
        .out(out1), .out_DK(dk1), .out_valid(v1), .locked(l1));

    deserializador_align #(.WIDTH(10), .COMMA(10'h17C), .LOCK_COUNT(1), .MAX_GAP(16)) u2 (
        .clk(clk), .rst_n(rst_n), .data(data), .en(en), .DK(dk),
        .out(out2), .out_DK(dk2), .out_valid(v2), .locked(l2));

    int checks = 0;
    int failures = 0;
    int strobes0 = 0;
    int strobes1 = 0;

    // Reference model: per instance, a sliding window of received bits, a
    // mode (0 hunting, 1 confirming, 2 locked) and the bit count since the
    // comma that set the word boundary.
    int          mw[3];
    logic [15:0] mcomma[3];
    int          mlc[3];
    int          mmg[3];
    logic [15:0] win[3];
    int          mode[3];
    int          since[3];
    int          nseen[3];
    int          gaps[3];
    logic [15:0] eout[3];
    logic        edk[3];
    logic        evalid[3];

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            win[k] = '0; mode[k] = 0; since[k] = 0; nseen[k] = 0; gaps[k] = 0;
            eout[k] = '0; edk[k] = 1'b0; evalid[k] = 1'b0;
        end
    endtask

    task automatic model_bit(input int k, input logic d, input logic e, input logic dkv);
        logic [15:0] mask;
        mask = (16'h1 << mw[k]) - 16'h1;
        evalid[k] = 1'b0;
        if (e) begin
            win[k] = ((win[k] << 1) | 16'(d)) & mask;
            if (mode[k] == 0) begin
                if (win[k] == mcomma[k]) begin
                    nseen[k] = 1; since[k] = 0; gaps[k] = 0;
                    mode[k] = (mlc[k] == 1) ? 2 : 1;
                end
            end else begin
                since[k]++;
                if (since[k] % mw[k] == 0) begin
                    if (mode[k] == 1) begin
                        if (win[k] == mcomma[k]) begin
                            nseen[k]++;
                            if (nseen[k] == mlc[k]) begin
                                mode[k] = 2; gaps[k] = 0;
                            end
                        end else begin
                            mode[k] = 0; nseen[k] = 0;
                        end
                    end else begin
                        evalid[k] = 1'b1; eout[k] = win[k]; edk[k] = dkv;
                        if (win[k] == mcomma[k]) gaps[k] = 0;
                        else begin
                            gaps[k]++;
                            if (mmg[k] > 0 && gaps[k] == mmg[k]) mode[k] = 0;
                        end
                    end
                end
            end
        end
    endtask

    task automatic check_all(input string tag);
        logic [15:0] o;
        logic d, v, l;
        for (int k = 0; k < 3; k++) begin
            case (k)
                0: begin o = 16'(out0); d = dk0; v = v0; l = l0; end
                1: begin o = 16'(out1); d = dk1; v = v1; l = l1; end
                default: begin o = 16'(out2); d = dk2; v = v2; l = l2; end
            endcase
            chk($sformatf("%s_u%0d_out", tag, k), o, eout[k]);
            chk($sformatf("%s_u%0d_dk", tag, k), 16'(d), 16'(edk[k]));
            chk($sformatf("%s_u%0d_valid", tag, k), 16'(v), 16'(evalid[k]));
            chk($sformatf("%s_u%0d_locked", tag, k), 16'(l), 16'(mode[k] == 2));
        end
    endtask

    task automatic step(input logic d, input logic e, input logic dkv);
        @(negedge clk);
        data = d; en = e; dk = dkv;
        @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) model_bit(k, d, e, dkv);
        if (v0) strobes0++;
        if (v1) strobes1++;
        check_all("step");
    endtask

    task automatic send(input logic [15:0] w, input int n, input logic dk_last, input bit gappy);
        for (int i = n - 1; i >= 0; i--) begin
            step(w[i], 1'b1, (i == 0) ? dk_last : 1'b0);
            if (gappy && ($urandom_range(0, 1) == 1)) step(1'($urandom), 1'b0, 1'($urandom));
        end
    endtask

    task automatic send_gap_each(input logic [15:0] w, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            step(w[i], 1'b1, 1'b0);
            step(1'($urandom), 1'b0, 1'($urandom));
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        en = 1'b0;
        #1;
        model_reset();
        check_all("reset");
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int s0;
        int r;
        mw[0] = 8;  mcomma[0] = 16'h0BC; mlc[0] = 3; mmg[0] = 4;
        mw[1] = 8;  mcomma[1] = 16'h0BC; mlc[1] = 3; mmg[1] = 0;
        mw[2] = 10; mcomma[2] = 16'h17C; mlc[2] = 1; mmg[2] = 16;
        model_reset();
        do_reset();

        // Lock at offset 3, then a data word carrying DK on its last bit.
        send(16'h2, 3, 1'b0, 0);
        send(16'hBC, 8, 1'b0, 0);
        send(16'hBC, 8, 1'b0, 0);
        send(16'hBC, 8, 1'b0, 0);
        chk("t2_locked", 16'(l0), 16'h1);
        send(16'h5A, 8, 1'b1, 0);
        chk("t2_out", 16'(out0), 16'h5A);
        chk("t2_dk", 16'(dk0), 16'h1);
        chk("t2_valid", 16'(v0), 16'h1);

        // Enable toggling every cycle: exactly one strobe.
        s0 = strobes0;
        send_gap_each(16'hA5, 8);
        chk("t4_out", 16'(out0), 16'hA5);
        chk("t4_strobes", 16'(strobes0 - s0), 16'h1);

        // Aligned comma clears the gap count; four non-comma words drop lock.
        send(16'hBC, 8, 1'b0, 0);
        chk("t5_comma_out", 16'(out0), 16'hBC);
        for (int i = 0; i < 3; i++) send(16'h11, 8, 1'b0, 0);
        chk("t5_still_locked", 16'(l0), 16'h1);
        send(16'h11, 8, 1'b0, 0);
        chk("t5_valid", 16'(v0), 16'h1);
        chk("t5_out", 16'(out0), 16'h11);
        chk("t5_unlocked", 16'(l0), 16'h0);
        chk("t5_nogap_locked", 16'(l1), 16'h1);

        // Asynchronous reset mid-word while u1 is locked.
        send(16'h3, 3, 1'b0, 0);
        do_reset();
        chk("t1_locked", 16'(l1), 16'h0);
        chk("t1_out", 16'(out1), 16'h0);
        s0 = strobes1;
        for (int i = 0; i < 4; i++) send(16'(8'h5A + i), 8, 1'b1, 0);
        chk("t1_no_strobe", 16'(strobes1 - s0), 16'h0);

        // Failed confirmation returns to hunting.
        do_reset();
        s0 = strobes0;
        send(16'hBC, 8, 1'b0, 0);
        send(16'hBC, 8, 1'b0, 0);
        send(16'h00, 8, 1'b0, 0);
        chk("t3_locked", 16'(l0), 16'h0);
        chk("t3_strobes", 16'(strobes0 - s0), 16'h0);

        // Ten-bit configuration locking on a single comma at offset 7.
        do_reset();
        send(16'h0, 7, 1'b0, 0);
        send(16'h17C, 10, 1'b0, 0);
        chk("t6_locked", 16'(l2), 16'h1);
        send(16'h3FF, 10, 1'b1, 0);
        chk("t6_out", 16'(out2), 16'h3FF);
        chk("t6_valid", 16'(v2), 16'h1);

        // Randomised mix of commas and random words with enable gaps.
        do_reset();
        for (int i = 0; i < 120; i++) begin
            r = $urandom_range(0, 5);
            case (r)
                0: send(16'hBC, 8, 1'($urandom), 1'($urandom));
                1: send(16'h17C, 10, 1'($urandom), 1'($urandom));
                default: send(16'($urandom), $urandom_range(1, 10), 1'($urandom), 1'($urandom));
            endcase
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
